// File: rtl/regfile_wb_ctrl.sv
// Write-back buffer and read-port controller in front of a 32x32 register file array.
// Buffers write-backs, drains one per cycle, decodes one-hot selects and forwards pending data.
module regfile_wb_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [AW-1:0]              wb_addr,
    input  logic [DW-1:0]              wb_data,
    input  logic                       wr_hold,
    input  logic [AW-1:0]              rd_addr_a,
    input  logic [AW-1:0]              rd_addr_b,
    output logic [(2**AW)-1:0]         write_sl,
    output logic [DW-1:0]              write_data,
    output logic [(2**AW)-1:0]         select_a,
    output logic [(2**AW)-1:0]         select_b,
    input  logic [DW-1:0]              rf_out_a,
    input  logic [DW-1:0]              rf_out_b,
    output logic [DW-1:0]              rd_data_a,
    output logic [DW-1:0]              rd_data_b,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic drain;
    logic push;
    logic pop;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    assign drain    = (count_q != '0) && !wr_hold;
    assign pop      = drain;
    assign wb_ready = (count_q < CW'(DEPTH)) || drain;
    // Register 0 writes complete the handshake but never occupy a slot.
    assign push     = wb_valid && wb_ready && (wb_addr != '0);
    assign pending  = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail_q] <= wb_addr;
                data_q[tail_q] <= wb_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Array write port driven purely from buffered state, never from wb_*.
    always_comb begin
        write_sl   = '0;
        write_data = '0;
        if (drain) begin
            write_sl   = onehot(addr_q[head_q]);
            write_data = data_q[head_q];
        end
    end

    assign select_a = (rd_addr_a == '0) ? '0 : onehot(rd_addr_a);
    assign select_b = (rd_addr_b == '0) ? '0 : onehot(rd_addr_b);

    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rf_out  [2];
    logic [DW-1:0] rd_data [2];
    logic [PW-1:0] idx;

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rf_out[0]  = rf_out_a;
    assign rf_out[1]  = rf_out_b;

    // Walk oldest to youngest so the last match is the youngest buffered value.
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = rf_out[p];
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (addr_q[idx] == rd_addr[p])) begin
                    rd_data[p] = data_q[idx];
                end
            end
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

    count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomised scoreboard bench for regfile_wb_ctrl with a behavioural register-array model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wr_hold;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] write_sl;
    logic [31:0] write_data;
    logic [31:0] select_a;
    logic [31:0] select_b;
    logic [31:0] rf_out_a;
    logic [31:0] rf_out_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    // Array seen by the DUT, and the bench's idea of what it should hold.
    logic [31:0] rf_mem  [32] = '{default: 32'h0};
    logic [31:0] ref_mem [32] = '{default: 32'h0};
    wr_t         ref_q [$];
    wr_t         exp_wr [$];

    regfile_wb_ctrl #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wr_hold    (wr_hold),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .write_sl   (write_sl),
        .write_data (write_data),
        .select_a   (select_a),
        .select_b   (select_b),
        .rf_out_a   (rf_out_a),
        .rf_out_b   (rf_out_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (write_sl[i]) rf_mem[i] <= write_data;
        end
    end

    assign rf_out_a = rf_mem[rd_addr_a];
    assign rf_out_b = rf_mem[rd_addr_b];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] ra);
        logic [31:0] r;
        if (ra == 5'd0) return 32'h0;
        r = ref_mem[ra];
        foreach (ref_q[i]) if (ref_q[i].a == ra) r = ref_q[i].d;
        return r;
    endfunction

    function automatic logic [31:0] sel(input logic [4:0] ra);
        return (ra == 5'd0) ? 32'h0 : (32'h1 << ra);
    endfunction

    // Monitor: every observed array write must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit  exp_drain = (exp_wr.size() != 0) && !wr_hold;
            automatic wr_t e;
            check("drain_active", 32'(write_sl != 32'h0), 32'(exp_drain));
            if (write_sl != 32'h0 && exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("write_sl", write_sl, 32'h1 << e.a);
                check("write_data", write_data, e.d);
            end else if (write_sl == 32'h0) begin
                check("idle_data", write_data, 32'h0);
            end
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input bit v, input logic [4:0] a, input logic [31:0] d, input bit hold,
                         input logic [4:0] ra, input logic [4:0] rb);
        bit exp_ready;
        bit drain;
        wr_t e;
        wb_valid  = v;
        wb_addr   = a;
        wb_data   = d;
        wr_hold   = hold;
        rd_addr_a = ra;
        rd_addr_b = rb;
        @(negedge clk);
        drain     = (ref_q.size() != 0) && !hold;
        exp_ready = (ref_q.size() < DEPTH) || drain;
        check("wb_ready", 32'(wb_ready), 32'(exp_ready));
        check("pending", 32'(pending), 32'(ref_q.size()));
        check("select_a", select_a, sel(ra));
        check("select_b", select_b, sel(rb));
        check("rd_data_a", rd_data_a, ref_read(ra));
        check("rd_data_b", rd_data_b, ref_read(rb));
        @(posedge clk);
        if (drain) begin
            e = ref_q.pop_front();
            ref_mem[e.a] = e.d;
        end
        if (v && exp_ready && a != 5'd0) begin
            e.a = a;
            e.d = d;
            ref_q.push_back(e);
            exp_wr.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input bit hold, input logic [4:0] ra, input logic [4:0] rb);
        cycle(1'b0, 5'd0, 32'h0, hold, ra, rb);
    endtask

    initial begin
        rst_n     = 1'b0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        wr_hold   = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        #3;
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_ready", 32'(wb_ready), 32'h1);
        check("rst_write_sl", write_sl, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, read back through forwarding then through the array.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0);
        idle(1'b0, 5'd5, 5'd5);
        idle(1'b0, 5'd5, 5'd0);

        // Forwarding of the youngest of two same-address entries.
        cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd7);
        cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd7);
        idle(1'b1, 5'd7, 5'd7);
        idle(1'b0, 5'd0, 5'd7);
        idle(1'b0, 5'd7, 5'd7);
        idle(1'b0, 5'd7, 5'd7);

        // Fill, hold off a 5th request, then release hold.
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'd10, 5'd13);
        cycle(1'b1, 5'd14, 32'hA004, 1'b1, 5'd11, 5'd14);
        cycle(1'b1, 5'd14, 32'hA004, 1'b0, 5'd12, 5'd14);
        for (int i = 0; i < 6; i++) idle(1'b0, 5'(10 + i), 5'd14);

        // Register zero is dropped at the handshake.
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0, 5'd0);

        // Streaming r1..r31, then read everything back.
        for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'hC0DE0000 | i, 1'b0, 5'(i), 5'(i - 1));
        for (int i = 1; i < 32; i++) idle(1'b0, 5'(i), 5'(32 - i));

        // Randomised traffic with a narrow address range to provoke forwarding hits.
        for (int n = 0; n < 400; n++) begin
            automatic logic [4:0] a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            automatic logic [4:0] ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            automatic logic [4:0] rb = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 2) != 0), a, $urandom, $urandom_range(0, 3) == 0, ra, rb);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b0, 5'd1, 5'd2);

        // Asynchronous reset with three writes still buffered: nothing reaches the array.
        cycle(1'b1, 5'd20, 32'h5EED0001, 1'b1, 5'd20, 5'd21);
        cycle(1'b1, 5'd21, 32'h5EED0002, 1'b1, 5'd20, 5'd21);
        cycle(1'b1, 5'd22, 32'h5EED0003, 1'b1, 5'd22, 5'd21);
        wb_valid = 1'b0;
        check("pre_rst_pending", 32'(pending), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_ready", 32'(wb_ready), 32'h1);
        check("mid_rst_write_sl", write_sl, 32'h0);
        ref_q.delete();
        exp_wr.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        wr_hold = 1'b0;
        @(posedge clk);
        #1;
        idle(1'b0, 5'd20, 5'd21);
        idle(1'b0, 5'd22, 5'd0);

        for (int i = 1; i < 32; i++) check($sformatf("array_r%0d", i), rf_mem[i], ref_mem[i]);
        check("array_r0", rf_mem[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
